// File: rtl/uart_pkg.sv
// uart_pkg
// Definitions shared by the 8N1 UART emitter and receiver: the frame
// format, the receiver state encoding and the bit-timer width helper.
// No ports.
package uart_pkg;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_t;

  // Width of a down-counter that must hold CLK_DIVIDER-1.
  function automatic int cnt_width(input int clk_divider);
    return (clk_divider > 2) ? $clog2(clk_divider) : 1;
  endfunction

endpackage

// File: rtl/uart_receiver_if.sv
// uart_receiver_if
// Byte delivery bundle between the UART receiver and its consumer.
//   o_data      received byte, stable while o_valid is high
//   o_valid     a byte is available
//   i_ready     consumer accepts the byte (transfer on o_valid & i_ready)
//   o_frame_err one-cycle pulse, stop bit sampled low
//   o_overrun   one-cycle pulse, completed byte dropped while one pending
//   o_busy      receiver is not idle
// master: the receiver side; slave: the consumer side.
interface uart_receiver_if;

  logic [uart_pkg::DATA_BITS-1:0] o_data;
  logic                           o_valid;
  logic                           i_ready;
  logic                           o_frame_err;
  logic                           o_overrun;
  logic                           o_busy;

  modport master (
    output o_data, o_valid, o_frame_err, o_overrun, o_busy,
    input  i_ready
  );

  modport slave (
    input  o_data, o_valid, o_frame_err, o_overrun, o_busy,
    output i_ready
  );

endinterface

// File: rtl/sync_ff.sv
// sync_ff
// N-stage synchroniser for an asynchronous single-bit input, with a
// parameterised reset value so the output holds a known level in reset.
//   clk    destination clock
//   reset  asynchronous, active-high reset
//   d      asynchronous input
//   q      synchronised output (last stage)
module sync_ff #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chain <= {STAGES{RESET_VAL}};
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/uart_receiver.sv
// uart_receiver
// 8N1 UART receiver, LSB first. The RX pin is synchronised, the start
// bit is validated at mid-bit, and the data and stop bits are sampled at
// bit centre. Bytes leave through a valid/ready handshake. Framing and
// overrun errors are flagged with one-cycle pulses.
//   clk        system clock
//   reset      asynchronous, active-high reset
//   i_uart_rx  serial line, asynchronous to clk, idle high
//   rx_if      byte/status bundle (master side)
//
// state | meaning
// IDLE  | line idle, waiting for a falling edge
// START | timing to mid start bit; a high sample there is a glitch
// DATA  | sampling 8 data bits at bit centre
// STOP  | sampling the stop bit; deliver, overrun or framing error
// BREAK | stop bit was low; wait for the line to return high
module uart_receiver
  import uart_pkg::*;
#(
  parameter int CLK_DIVIDER = 50,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_uart_rx,
  uart_receiver_if.master rx_if
);

  localparam int CNT_W = cnt_width(CLK_DIVIDER);
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(CLK_DIVIDER - 1);
  localparam logic [CNT_W-1:0] CNT_HALF   = CNT_W'(CLK_DIVIDER / 2 - 1);
  localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
  localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

  logic rx_s;
  logic rx_d;

  rx_state_t            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2:0]           idx_q, idx_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;
  logic                 sample;

  // Reset value 1 matches an idle line, so releasing reset cannot fake a
  // start edge.
  sync_ff #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (1'b1)
  ) u_sync_rx (
    .clk   (clk),
    .reset (reset),
    .d     (i_uart_rx),
    .q     (rx_s)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_d    <= 1'b1;
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      rx_d    <= rx_s;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign sample = (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = sample ? CNT_RELOAD : cnt_q - 1'b1;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    // A pending byte is consumed by any cycle with i_ready high.
    valid_d = valid_q & ~rx_if.i_ready;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = cnt_q;
        if (rx_d && !rx_s) begin
          state_d = START;
          cnt_d   = CNT_HALF;
        end
      end

      START: begin
        if (sample) begin
          if (rx_s) begin
            state_d = IDLE;
          end else begin
            state_d = DATA;
            idx_d   = '0;
          end
        end
      end

      DATA: begin
        if (sample) begin
          shreg_d = {rx_s, shreg_q[DATA_BITS-1:1]};
          if (idx_q == LAST_DATA) begin
            state_d = STOP;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end

      STOP: begin
        if (sample) begin
          if (!rx_s) begin
            ferr_d  = 1'b1;
            state_d = BREAK;
          end else if (idx_q != LAST_STOP) begin
            idx_d = idx_q + 3'd1;
          end else begin
            state_d = IDLE;
            // Loading is allowed when the slot is free or is being emptied
            // in this same cycle; otherwise the new byte is the one lost.
            if (!valid_q || rx_if.i_ready) begin
              data_d  = shreg_q;
              valid_d = 1'b1;
            end else begin
              ovr_d = 1'b1;
            end
          end
        end
      end

      BREAK: begin
        if (rx_s) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign rx_if.o_data      = data_q;
  assign rx_if.o_valid     = valid_q;
  assign rx_if.o_frame_err = ferr_q;
  assign rx_if.o_overrun   = ovr_q;
  assign rx_if.o_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver
// Self-checking bench for uart_receiver. Three instances cover
// CLK_DIVIDER 8, 50 and 7 (the last with three synchroniser stages).
// Expected bytes and error counts come from a frame-level model: every
// frame sent with a good stop bit and a free (or freed) output slot must
// appear once, in order, on the handshake.
module tb_uart_receiver;

  logic clk = 1'b0;
  logic reset;
  logic rx[3];
  logic ready[3];

  always #5 clk = ~clk;

  uart_receiver_if bus0 ();
  uart_receiver_if bus1 ();
  uart_receiver_if bus2 ();

  assign bus0.i_ready = ready[0];
  assign bus1.i_ready = ready[1];
  assign bus2.i_ready = ready[2];

  logic [7:0] data_o[3];
  logic       valid_o[3];
  logic       fe_o[3];
  logic       ov_o[3];
  logic       busy_o[3];

  assign data_o[0] = bus0.o_data;  assign valid_o[0] = bus0.o_valid;
  assign fe_o[0]   = bus0.o_frame_err; assign ov_o[0] = bus0.o_overrun;
  assign busy_o[0] = bus0.o_busy;
  assign data_o[1] = bus1.o_data;  assign valid_o[1] = bus1.o_valid;
  assign fe_o[1]   = bus1.o_frame_err; assign ov_o[1] = bus1.o_overrun;
  assign busy_o[1] = bus1.o_busy;
  assign data_o[2] = bus2.o_data;  assign valid_o[2] = bus2.o_valid;
  assign fe_o[2]   = bus2.o_frame_err; assign ov_o[2] = bus2.o_overrun;
  assign busy_o[2] = bus2.o_busy;

  uart_receiver #(.CLK_DIVIDER(8), .SYNC_STAGES(2)) dut0 (
    .clk(clk), .reset(reset), .i_uart_rx(rx[0]), .rx_if(bus0));
  uart_receiver #(.CLK_DIVIDER(50), .SYNC_STAGES(2)) dut1 (
    .clk(clk), .reset(reset), .i_uart_rx(rx[1]), .rx_if(bus1));
  uart_receiver #(.CLK_DIVIDER(7), .SYNC_STAGES(3)) dut2 (
    .clk(clk), .reset(reset), .i_uart_rx(rx[2]), .rx_if(bus2));

  function automatic int div_of(input int i);
    case (i)
      0:       return 8;
      1:       return 50;
      default: return 7;
    endcase
  endfunction

  function automatic int sync_of(input int i);
    return (i == 2) ? 3 : 2;
  endfunction

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Monitor: everything the consumer sees, per instance.
  logic [7:0] got_q[3][$];
  int fe_cnt[3]  = '{0, 0, 0};
  int ov_cnt[3]  = '{0, 0, 0};
  int vcyc[3]    = '{0, 0, 0};
  int both_cnt   = 0;

  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 3; i++) begin
        if (valid_o[i] && ready[i]) got_q[i].push_back(data_o[i]);
        if (fe_o[i])    fe_cnt[i] <= fe_cnt[i] + 1;
        if (ov_o[i])    ov_cnt[i] <= ov_cnt[i] + 1;
        if (valid_o[i]) vcyc[i]   <= vcyc[i] + 1;
      end
      if ((fe_o[0] && ov_o[0]) || (fe_o[1] && ov_o[1]) || (fe_o[2] && ov_o[2]))
        both_cnt <= both_cnt + 1;
    end
  end

  // Reference model: bytes that must be delivered, in order.
  logic [7:0] exp_q[3][$];
  int got_rd[3] = '{0, 0, 0};

  task automatic cmp_q(input int i, input string tag);
    int n_got;
    n_got = got_q[i].size() - got_rd[i];
    chk({tag, "_count"}, n_got, exp_q[i].size());
    for (int k = 0; k < exp_q[i].size() && k < n_got; k++)
      chk($sformatf("%s_byte%0d", tag, k), got_q[i][got_rd[i] + k], exp_q[i][k]);
    got_rd[i] = got_q[i].size();
    exp_q[i].delete();
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive one 8N1 frame starting at a negedge. A bad stop bit can be
  // extended into a held-low break of hold_bits extra bit times.
  task automatic send_frame(input int i, input logic [7:0] b, input bit stop_ok,
                            input int hold_bits);
    logic [9:0] bits;
    bits = {stop_ok, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      rx[i] = bits[k];
      repeat (div_of(i)) @(negedge clk);
    end
    if (!stop_ok) repeat (hold_bits * div_of(i)) @(negedge clk);
    rx[i] = 1'b1;
  endtask

  initial begin
    int d, h, lat, fe0, ov0, vc0, nfr, n_fe_exp;
    logic [7:0] b;
    bit ok;

    for (int i = 0; i < 3; i++) begin
      rx[i]    = 1'b1;
      ready[i] = 1'b0;
    end
    reset = 1'b1;
    idle(3);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_data%0d", i),  data_o[i],  0);
      chk($sformatf("rst_valid%0d", i), valid_o[i], 0);
      chk($sformatf("rst_ferr%0d", i),  fe_o[i],    0);
      chk($sformatf("rst_ovr%0d", i),   ov_o[i],    0);
      chk($sformatf("rst_busy%0d", i),  busy_o[i],  0);
    end
    reset = 1'b0;
    idle(5);

    // Back-to-back 0x55, 0xA3 at divider 8 with the consumer always ready.
    d = div_of(0); h = d / 2;
    ready[0] = 1'b1;
    fe0 = fe_cnt[0]; ov0 = ov_cnt[0]; vc0 = vcyc[0];
    lat = 0;
    fork
      begin
        send_frame(0, 8'h55, 1'b1, 0);
        send_frame(0, 8'hA3, 1'b1, 0);
      end
      begin
        int n;
        n = 0;
        while (n < 200 && !valid_o[0]) begin
          @(posedge clk);
          n++;
          @(negedge clk);
        end
        lat = n;
      end
    join
    idle(2 * d);
    // Edges from the pin falling to o_valid: synchroniser, edge flop,
    // half a bit, nine bits.
    chk("b2b_latency", lat, sync_of(0) + 1 + h + 9 * d);
    exp_q[0].push_back(8'h55);
    exp_q[0].push_back(8'hA3);
    cmp_q(0, "b2b");
    chk("b2b_valid_cycles", vcyc[0] - vc0, 2);
    chk("b2b_ferr", fe_cnt[0] - fe0, 0);
    chk("b2b_ovr", ov_cnt[0] - ov0, 0);

    // Three-cycle low glitch: START rejects it at mid-bit.
    fe0 = fe_cnt[0]; vc0 = vcyc[0];
    rx[0] = 1'b0;
    for (int e = 1; e <= 3 + h; e++) begin
      @(negedge clk);
      if (e == 3) rx[0] = 1'b1;
      if (e == 2 + h) chk("glitch_busy_in_start", busy_o[0], 1);
    end
    chk("glitch_busy_after", busy_o[0], 0);
    chk("glitch_valid_after", valid_o[0], 0);
    chk("glitch_ferr_after", fe_o[0], 0);
    idle(2 * d);
    chk("glitch_valid_cycles", vcyc[0] - vc0, 0);
    chk("glitch_ferr_count", fe_cnt[0] - fe0, 0);

    // Bad stop bit, then break held for 30 bit times, then a good frame.
    fe0 = fe_cnt[0]; ov0 = ov_cnt[0]; vc0 = vcyc[0];
    send_frame(0, 8'h3C, 1'b0, 30);
    chk("break_busy_held", busy_o[0], 1);
    chk("break_valid_held", valid_o[0], 0);
    idle(2 * d);
    chk("break_busy_released", busy_o[0], 0);
    chk("break_ferr_count", fe_cnt[0] - fe0, 1);
    chk("break_valid_cycles", vcyc[0] - vc0, 0);
    send_frame(0, 8'h81, 1'b1, 0);
    idle(2 * d);
    exp_q[0].push_back(8'h81);
    cmp_q(0, "after_break");
    chk("after_break_ferr", fe_cnt[0] - fe0, 1);
    chk("after_break_ovr", ov_cnt[0] - ov0, 0);

    // Consumer stalled across two frames: second byte dropped.
    ready[0] = 1'b0;
    ov0 = ov_cnt[0]; fe0 = fe_cnt[0];
    send_frame(0, 8'h11, 1'b1, 0);
    send_frame(0, 8'h22, 1'b1, 0);
    idle(d);
    chk("ovr_valid", valid_o[0], 1);
    chk("ovr_data_held", data_o[0], 8'h11);
    chk("ovr_pulse_count", ov_cnt[0] - ov0, 1);
    chk("ovr_ferr", fe_cnt[0] - fe0, 0);
    ready[0] = 1'b1;
    idle(2 * d);
    exp_q[0].push_back(8'h11);
    cmp_q(0, "ovr_drain");
    chk("ovr_valid_drained", valid_o[0], 0);

    // Accept exactly in the second frame's stop-sample cycle: no overrun.
    ready[0] = 1'b0;
    ov0 = ov_cnt[0];
    fork
      begin
        send_frame(0, 8'h11, 1'b1, 0);
        send_frame(0, 8'h22, 1'b1, 0);
      end
      begin
        repeat (10 * d + sync_of(0) + h + 9 * d) @(negedge clk);
        ready[0] = 1'b1;
        @(negedge clk);
        ready[0] = 1'b0;
      end
    join
    idle(d);
    chk("same_cycle_ovr", ov_cnt[0] - ov0, 0);
    chk("same_cycle_valid", valid_o[0], 1);
    chk("same_cycle_data", data_o[0], 8'h22);
    exp_q[0].push_back(8'h11);
    cmp_q(0, "same_cycle_first");
    ready[0] = 1'b1;
    idle(d);
    exp_q[0].push_back(8'h22);
    cmp_q(0, "same_cycle_second");

    // Reset in the middle of data bit 4, then a clean 0xF0, per divider.
    for (int i = 0; i < 3; i++) begin
      logic [5:0] part;
      d = div_of(i);
      ready[i] = 1'b1;
      part = {5'b11010, 1'b0};
      for (int k = 0; k < 6; k++) begin
        rx[i] = part[k];
        repeat ((k == 5) ? d / 2 : d) @(negedge clk);
      end
      reset = 1'b1;
      @(negedge clk);
      chk($sformatf("midrst_data%0d", i),  data_o[i],  0);
      chk($sformatf("midrst_valid%0d", i), valid_o[i], 0);
      chk($sformatf("midrst_busy%0d", i),  busy_o[i],  0);
      chk($sformatf("midrst_ferr%0d", i),  fe_o[i],    0);
      rx[i] = 1'b1;
      idle(3);
      reset = 1'b0;
      vc0 = vcyc[i];
      idle(2 * d);
      chk($sformatf("midrst_no_partial%0d", i), vcyc[i] - vc0, 0);
      send_frame(i, 8'hF0, 1'b1, 0);
      idle(2 * d);
      exp_q[i].push_back(8'hF0);
      cmp_q(i, $sformatf("midrst_rx%0d", i));
    end

    // Random frames, random gaps, occasional bad stop bits.
    for (int i = 0; i < 3; i++) begin
      d = div_of(i);
      ready[i] = 1'b1;
      fe0 = fe_cnt[i]; ov0 = ov_cnt[i];
      n_fe_exp = 0;
      nfr = (i == 1) ? 5 : 12;
      for (int f = 0; f < nfr; f++) begin
        b  = 8'($urandom_range(0, 255));
        ok = ($urandom_range(0, 5) != 0);
        send_frame(i, b, ok, 0);
        if (ok) begin
          exp_q[i].push_back(b);
          idle($urandom_range(0, d));
        end else begin
          n_fe_exp++;
          idle($urandom_range(d, 2 * d));
        end
      end
      idle(2 * d);
      cmp_q(i, $sformatf("rand%0d", i));
      chk($sformatf("rand_ferr%0d", i), fe_cnt[i] - fe0, n_fe_exp);
      chk($sformatf("rand_ovr%0d", i), ov_cnt[i] - ov0, 0);
    end

    chk("no_simultaneous_err_pulses", both_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
- UART receiver (8N1, LSB first) that pairs with the existing 8N1 emitter UART. Its bit timing uses the same clock-divider convention as the emitter.
- Samples the asynchronous RX pin with a clock-domain synchroniser and validates the start bit at mid-bit. It then samples each data bit and the stop bit at bit centre.
- Delivers each byte through a valid/ready handshake and flags framing and overrun errors.
- Sits at the SOC top level behind an input pin. It feeds command/config logic, such as a future TDC control register.

Parameters:
- CLK_DIVIDER, 50, clock cycles per bit (50 MHz / 50 = 1 Mbaud). Legal range 4..65535.
- SYNC_STAGES, 2, number of input synchroniser flops. Legal range 2..3.

Ports:
- clk  input  1  system clock; the single clock domain.
- reset  input  1  asynchronous, active-high reset.
- i_uart_rx  input  1  serial line, asynchronous to clk; idle high.
- o_data  output  8  received byte; stable while o_valid is high.
- o_valid  output  1  a byte is available.
- i_ready  input  1  consumer accepts the byte; a transfer occurs when o_valid & i_ready.
- o_frame_err  output  1  one-cycle pulse: stop bit sampled low.
- o_overrun  output  1  one-cycle pulse: a completed byte was dropped because the previous byte was still pending.
- o_busy  output  1  high whenever the state is not IDLE.

Behaviour:
- Reset:
  - Takes effect asynchronously at any time, including mid-frame.
  - Synchroniser flops reset to 1 (idle line), so a false start cannot be detected on release.
  - State goes to IDLE; counters and the shift register clear.
  - o_data=0, o_valid=0, o_frame_err=0, o_overrun=0, o_busy=0.
- Synchroniser: rx_s is the output of the last of SYNC_STAGES flops; edge detection uses one further flop (rx_d).
- Cycle reference: t0 is the cycle in which the IDLE state sees rx_d=1 and rx_s=0 (falling edge).
- Bit counter:
  - Width $clog2(CLK_DIVIDER).
  - A sample event occurs when the counter equals 0; the counter then reloads with CLK_DIVIDER-1.
  - On a falling edge in IDLE, it loads CLK_DIVIDER/2-1 (integer division).
- Sample times: start bit at t0+CLK_DIVIDER/2; data bit k (k=0..7) at t0+CLK_DIVIDER/2+(k+1)*CLK_DIVIDER; stop bit at t0+CLK_DIVIDER/2+9*CLK_DIVIDER.
- States and transitions:
  - IDLE: a falling edge moves to START.
  - START: at the sample event, rx_s=1 is a glitch and returns to IDLE with no flags raised. rx_s=0 moves to DATA with bit index 0.
  - DATA: at each sample event, shift rx_s into bit 7 of the shift register (shift right), so bit 0 is received first. After index 7 the state moves to STOP.
  - STOP, sample event, rx_s=1 (good stop bit):
    - If o_valid=0, or o_valid & i_ready in this cycle: load o_data with the shift register and set o_valid=1 the next cycle.
    - Otherwise: drop the new byte, pulse o_overrun for 1 cycle, and keep o_data and o_valid unchanged.
    - In both cases go to IDLE.
  - STOP, sample event, rx_s=0 (bad stop bit): pulse o_frame_err for 1 cycle, discard the byte, go to BREAK.
  - BREAK: wait until rx_s=1, then go to IDLE. A held-low line (break) therefore yields exactly one frame error and no spurious bytes.
- Back-to-back frames: IDLE is re-entered at the stop-bit centre. A start edge arriving from half a bit after that point is accepted, so minimum spacing is tolerated.
- Handshake:
  - o_valid stays high and o_data stays stable until a cycle with i_ready=1.
  - o_valid clears the cycle after acceptance unless a new byte loads in the same cycle, in which case o_valid stays high with the new data.
  - i_ready is ignored while o_valid=0.
- Latency from the first low sample at the pin: SYNC_STAGES+1 cycles to t0, plus the stop sample time, plus 1 cycle to o_valid.
- Error pulses are registered outputs and never assert together.

Decomposition:
- Shared package uart_pkg holds:
  - localparams for frame format: DATA_BITS=8, STOP_BITS=1.
  - the state encoding IDLE/START/DATA/STOP/BREAK.
  - a function returning the counter width for a given CLK_DIVIDER.
  - The emitter adopts the same package.
- One natural sub-module: sync_ff, an N-stage synchroniser with parameterised reset value (1 here). It is reusable for other pins such as tdc_in.
- The FSM, counter and output register live in uart_receiver.

Test Plan:
- CLK_DIVIDER=8, send 0x55 then 0xA3 back-to-back with i_ready=1 -> o_data=0x55 then 0xA3. o_valid is high for 1 cycle each, first at t0+4+72+1. No error pulses.
- Low glitch of 3 cycles in IDLE -> START returns to IDLE; o_valid, o_frame_err and o_busy are low again 4+1 cycles after t0.
- Frame 0x3C with the stop bit driven low, then the line held low for 30 bit times -> exactly one o_frame_err pulse. o_valid stays 0, state stays BREAK until the line goes high, then the next frame 0x81 is received correctly.
- i_ready=0, send 0x11 then 0x22 -> o_data holds 0x11 and one o_overrun pulses at the second stop sample. With i_ready then raised, 0x11 is delivered once and 0x22 is never delivered.
- i_ready asserted exactly in the second frame's stop-sample cycle -> no overrun, 0x11 accepted, o_valid stays 1 with o_data=0x22.
- Assert reset in the middle of data bit 4, release it, then send 0xF0 -> outputs read 0 during reset, no partial byte is emitted, and 0xF0 is received intact. Repeat at CLK_DIVIDER=50 and 7 (odd).
